var_delay_vld: RTL and testbench
================================

VAR_DELAY_VLD -- requirements
Module: var_delay_vld

Interface
REQ-001 SHALL have parameter MAX_N, default 16, meaning maximum delay in enabled cycles (legal range 2..256).
REQ-002 SHALL have parameter BITS, default 8, meaning data width.
REQ-003 SHALL have parameter RST_N, default 4, meaning delay in effect after reset (legal range 1..MAX_N).
REQ-004 SHALL define CW = $clog2(MAX_N+1) as the width of delay fields.
REQ-005 SHALL have port i_clk, input, 1, clock; all state updates on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port i_en, input, 1, advance enable; the pipeline shifts only on edges with i_en=1.
REQ-008 SHALL have port i_flush, input, 1, clears all in-flight samples.
REQ-009 SHALL have port i_valid, input, 1, input sample qualifier.
REQ-010 SHALL have port i_d, input, BITS, input sample.
REQ-011 SHALL have port i_cfg_load, input, 1, single-cycle request to change delay.
REQ-012 SHALL have port i_cfg_n, input, CW, requested delay.
REQ-013 SHALL have port o_ready, output, 1, input accepted this cycle.
REQ-014 SHALL have port o_valid, output, 1, output sample qualifier.
REQ-015 SHALL have port o_q, output, BITS, delayed sample.
REQ-016 SHALL have port o_cur_n, output, CW, delay currently in effect.
REQ-017 SHALL have port o_busy, output, 1, high when any valid sample is held in stages 0..o_cur_n-1.

Function
REQ-018 SHALL hold MAX_N stages, each with BITS data and 1 valid bit.
REQ-019 On an edge with i_en=1, SHALL load stage0 with {i_valid & o_ready, i_d} and stage k with stage k-1 (k=1..MAX_N-1).
REQ-020 On an edge with i_en=0, SHALL hold all stages; i_valid in that cycle is discarded.
REQ-021 SHALL drive o_valid = valid bit of stage o_cur_n-1 and o_q = that stage's data when o_valid=1, else 0 (combinational tap).
REQ-022 Latency: a sample accepted on enabled edge E SHALL appear on o_q/o_valid after exactly o_cur_n enabled edges, counting E; with i_en held high, this is o_cur_n cycles.
REQ-023 SHALL clamp requested delays: 0 becomes 1, values above MAX_N become MAX_N.
REQ-024 SHALL implement a two-state FSM, RUN and DRAIN; o_ready = 1 in RUN and 0 in DRAIN.
REQ-025 In RUN, on i_cfg_load with o_busy=0, SHALL set o_cur_n to the clamped value on that edge and remain in RUN.
REQ-026 In RUN, on i_cfg_load with o_busy=1, SHALL store the clamped value as pending and enter DRAIN.
REQ-027 In DRAIN, stages SHALL keep shifting with i_en, with stage0 valid forced to 0.
REQ-028 In DRAIN, when o_busy=0, SHALL copy pending into o_cur_n and return to RUN on the next edge.
REQ-029 In DRAIN, a further i_cfg_load SHALL overwrite pending (last request wins) and SHALL NOT restart the drain.
REQ-030 A cfg request equal to o_cur_n SHALL still follow REQ-025/026; no shortcut.
REQ-031 i_flush SHALL take effect regardless of i_en: clears all valid bits and data to 0; if in DRAIN, applies pending to o_cur_n and enters RUN; i_valid that cycle is discarded.
REQ-032 i_flush with i_cfg_load in the same cycle SHALL clear the stages and set o_cur_n to the clamped i_cfg_n, ending in RUN.
REQ-033 Stages at index >= o_cur_n SHALL NOT affect o_valid, o_q or o_busy.
REQ-034 When o_cur_n shrinks, samples beyond the new tap SHALL never be emitted; drain guarantees none are valid at switch time.

Reset
REQ-035 While i_rst_n=0 at an edge, SHALL clear all stage data and valid bits to 0, set o_cur_n=RST_N, pending=RST_N, FSM=RUN.
REQ-036 After reset, outputs SHALL be o_valid=0, o_q=0, o_ready=1, o_busy=0, o_cur_n=RST_N.
REQ-037 Reset SHALL override i_flush, i_cfg_load and i_en, including when asserted mid-drain.

Verification
REQ-038 Reset, i_en=1, 10 consecutive valid samples 1..10 -> o_valid first high 4 cycles after the first accept with o_q=1, then 2..10 on consecutive cycles.
REQ-039 Delay 4, i_en toggles 1,0,1,0 with one sample 0xA5 -> 0xA5 appears after exactly 4 enabled edges; o_q holds during i_en=0.
REQ-040 Pipeline empty, i_cfg_load with i_cfg_n=0, then =MAX_N+5 -> o_cur_n=1, then o_cur_n=MAX_N; o_ready stays 1.
REQ-041 Delay 8 with 3 samples in flight, load 2 -> o_ready=0, the 3 samples emerge at delay 8, o_cur_n=2 on the edge after o_busy falls, o_ready=1.
REQ-042 Mid-drain second load 6, then i_flush -> all valids cleared, o_cur_n=6, RUN, no stale samples emitted.
REQ-043 i_rst_n=0 mid-drain with samples in flight -> next cycle o_valid=0, o_cur_n=RST_N, o_ready=1.

Source files
------------

// File: rtl/var_delay_vld.sv
// var_delay_vld: a shift-register delay line whose length can be changed at run time.
// Each stage holds one data word and one valid bit. The output is tapped at stage
// o_cur_n-1. A shorter delay only takes effect once the taps in front of the current
// output hold no valid samples. Until then the FSM sits in DRAIN and stops accepting
// input, so no sample is ever cut off or duplicated by a delay change.
module var_delay_vld #(
   parameter int MAX_N   = 16,                   // maximum delay in enabled cycles, 2..256
   parameter int BITS    = 8,                    // data width
   parameter int RST_N   = 4,                    // delay after reset, 1..MAX_N
   localparam int CW     = $clog2(MAX_N + 1)     // width of delay fields
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic            i_flush,
   input  logic            i_valid,
   input  logic [BITS-1:0] i_d,
   input  logic            i_cfg_load,
   input  logic [CW-1:0]   i_cfg_n,
   output logic            o_ready,
   output logic            o_valid,
   output logic [BITS-1:0] o_q,
   output logic [CW-1:0]   o_cur_n,
   output logic            o_busy
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Pipeline storage
   logic [BITS-1:0]  data_r [MAX_N];
   logic [MAX_N-1:0] vld_r;

   // Control state
   logic [0:0]       state_r;
   logic [CW-1:0]    cur_n_r;
   logic [CW-1:0]    pend_r;

   // Derived signals
   logic [CW-1:0]    cfg_clamped;
   logic [CW-1:0]    tap_idx;
   logic [MAX_N-1:0] tap_mask;
   logic             tap_vld;
   logic [BITS-1:0]  tap_dat;
   logic             busy;
   logic             ready;

   assign ready   = (state_r == ST_RUN);
   assign tap_idx = cur_n_r - CW'(1);

   // Clamp the requested delay into 1..MAX_N
   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      cfg_clamped = i_cfg_n;
      if (i_cfg_n == '0) begin
         cfg_clamped = CW'(1);
      end else if (i_cfg_n > CW'(MAX_N)) begin
         cfg_clamped = CW'(MAX_N);
      end
   end

   // Mark the stages that lie in front of the output tap (indices 0..cur_n-1)
   always_comb begin
      tap_mask = '0;
      for (int k = 0; k < MAX_N; k++) begin
         tap_mask[k] = (CW'(k) < cur_n_r);
      end
   end

   // Select the tap stage. An explicit compare loop keeps the index width independent of MAX_N.
   always_comb begin
      tap_vld = 1'b0;
      tap_dat = '0;
      for (int k = 0; k < MAX_N; k++) begin
         if (CW'(k) == tap_idx) begin
            tap_vld = vld_r[k];
            tap_dat = data_r[k];
         end
      end
   end

   // A sample still waiting to reach the tap keeps the line busy
   assign busy = |(vld_r & tap_mask);

   // Shift register: reset/flush clear it, otherwise it advances on enabled edges
   // NOTE: sequential state uses non-blocking assignments, so every stage samples its neighbour's pre-edge value.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         // NOTE: the data words are cleared as well as the valid bits, so a flushed or reset line never shows stale data on o_q.
         for (int k = 0; k < MAX_N; k++) begin
            data_r[k] <= '0;
         end
         vld_r <= '0;
      end else if (i_en) begin
         data_r[0] <= i_d;
         vld_r[0]  <= i_valid & ready;
         for (int k = 1; k < MAX_N; k++) begin
            data_r[k] <= data_r[k-1];
            // A sample that moves past the tap is retired. A later, longer delay
            // then cannot present it a second time.
            vld_r[k]  <= vld_r[k-1] & tap_mask[k];
         end
      end
   end

   // Delay-change FSM: apply at once when the line is idle, otherwise drain first
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= ST_RUN;
         cur_n_r <= CW'(RST_N);
         pend_r  <= CW'(RST_N);
      end else if (i_flush) begin
         // After a flush the line is empty. A simultaneous request wins.
         // Otherwise a pending drain request is applied.
         if (i_cfg_load) begin
            cur_n_r <= cfg_clamped;
            pend_r  <= cfg_clamped;
         end else if (state_r == ST_DRAIN) begin
            cur_n_r <= pend_r;
         end
         state_r <= ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (i_cfg_load) begin
                  if (!busy) begin
                     cur_n_r <= cfg_clamped;
                  end else begin
                     pend_r  <= cfg_clamped;
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // The last request wins, even on the edge that ends the drain
               if (i_cfg_load) begin
                  pend_r <= cfg_clamped;
               end
               if (!busy) begin
                  cur_n_r <= i_cfg_load ? cfg_clamped : pend_r;
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end
   end

   assign o_ready = ready;
   assign o_valid = tap_vld;
   assign o_q     = tap_vld ? tap_dat : '0;
   assign o_cur_n = cur_n_r;
   assign o_busy  = busy;

endmodule

// File: tb/tb_var_delay_vld.sv
// tb_var_delay_vld: scoreboard bench for var_delay_vld.
// The reference model tracks each accepted sample by the enabled-edge count at which
// it must be visible. It follows the delay-change rules (immediate when idle,
// drain when busy, flush, reset) without modelling individual stages.
module tb_var_delay_vld;

   localparam int MAX_N = 16;
   localparam int BITS  = 8;
   localparam int RST_N = 4;
   localparam int CW    = $clog2(MAX_N + 1);

   logic            clk;
   logic            rst_n;
   logic            en;
   logic            flush;
   logic            valid;
   logic [BITS-1:0] d;
   logic            cfg_load;
   logic [CW-1:0]   cfg_n;
   logic            ready;
   logic            q_valid;
   logic [BITS-1:0] q;
   logic [CW-1:0]   cur_n;
   logic            busy;

   var_delay_vld #(.MAX_N(MAX_N), .BITS(BITS), .RST_N(RST_N)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_flush    (flush),
      .i_valid    (valid),
      .i_d        (d),
      .i_cfg_load (cfg_load),
      .i_cfg_n    (cfg_n),
      .o_ready    (ready),
      .o_valid    (q_valid),
      .o_q        (q),
      .o_cur_n    (cur_n),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [BITS-1:0] data;
      int              due;
   } exp_t;

   // Reference model state
   exp_t sb[$];          // expected outputs, in order, for the monitor
   int   dues[$];        // due counts of samples still in flight
   int   en_cnt = 0;     // enabled edges seen so far (never reset)
   int   gen    = 0;     // bumped on every reset or flush
   int   m_cur  = RST_N;
   int   m_pend = RST_N;
   bit   m_drain = 1'b0;

   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic int clampn(input int n);
      if (n == 0) return 1;
      if (n > MAX_N) return MAX_N;
      return n;
   endfunction

   // The line is busy while any sample has not yet reached the tap
   function automatic bit m_busy();
      foreach (dues[i]) if (dues[i] >= en_cnt) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one cycle of inputs at the falling edge and advance the model to the
   // state that the next rising edge will produce.
   task automatic step(input bit r_n, input bit e, input bit v, input int data,
                       input bit ld, input int n, input bit fl);
      bit acc;
      bit b;
      int new_cur;
      @(negedge clk);
      rst_n    = r_n;
      en       = e;
      valid    = v;
      d        = BITS'(data);
      cfg_load = ld;
      cfg_n    = CW'(n);
      flush    = fl;
      if (!r_n) begin
         sb.delete(); dues.delete(); gen++;
         m_cur = RST_N; m_pend = RST_N; m_drain = 1'b0;
      end else if (fl) begin
         sb.delete(); dues.delete(); gen++;
         if (ld) begin
            m_cur = clampn(n); m_pend = m_cur;
         end else if (m_drain) begin
            m_cur = m_pend;
         end
         m_drain = 1'b0;
      end else begin
         b       = m_busy();
         acc     = e && v && !m_drain;
         new_cur = m_cur;
         if (!m_drain) begin
            if (ld) begin
               if (!b) new_cur = clampn(n);
               else begin m_pend = clampn(n); m_drain = 1'b1; end
            end
         end else begin
            if (ld) m_pend = clampn(n);
            if (!b) begin new_cur = m_pend; m_drain = 1'b0; end
         end
         if (e) begin
            en_cnt++;
            while (dues.size() > 0 && dues[0] < en_cnt) void'(dues.pop_front());
            if (acc) begin
               dues.push_back(en_cnt + new_cur - 1);
               sb.push_back('{data: BITS'(data), due: en_cnt + new_cur - 1});
            end
         end
         m_cur = new_cur;
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input int n);
      step(1, 1, 0, 0, 1, n, 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input string name, input int budget);
      for (int i = 0; i < budget && !ready; i++) begin
         idle(1);
         settle();
      end
      if (!ready) fail_now({name, "_timeout"});
   endtask

   // Monitor: compare every presented output with the scoreboard, and check the
   // control outputs against the model after every edge.
   initial begin
      bit              have_held = 1'b0;
      int              held_gen  = -1;
      int              held_due  = -1;
      logic [BITS-1:0] held_d    = '0;
      exp_t            e;
      forever begin
         @(posedge clk);
         #1;
         check("cur_n", int'(cur_n), m_cur);
         check("ready", int'(ready), int'(!m_drain));
         check("busy",  int'(busy),  int'(m_busy()));
         if (q_valid) begin
            if (have_held && held_gen == gen && held_due == en_cnt) begin
               check("hold_q", int'(q), int'(held_d));
            end else if (sb.size() == 0) begin
               fail_now("unexpected_valid");
            end else begin
               e = sb.pop_front();
               check("data", int'(q), int'(e.data));
               check("latency_cnt", en_cnt, e.due);
               have_held = 1'b1; held_gen = gen; held_due = e.due; held_d = e.data;
            end
         end else begin
            check("q_idle_zero", int'(q), 0);
            if (sb.size() > 0 && sb[0].due <= en_cnt) begin
               fail_now("missing_valid");
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; flush = 1'b0; valid = 1'b0;
      d = '0; cfg_load = 1'b0; cfg_n = '0;

      // Reset and idle output state
      step(0, 1, 1, 8'h55, 1, 7, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      settle();
      check("rst_valid", int'(q_valid), 0);
      check("rst_q", int'(q), 0);
      check("rst_ready", int'(ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_cur_n", int'(cur_n), RST_N);

      // Ten back-to-back samples at the reset delay
      for (int i = 1; i <= 10; i++) step(1, 1, 1, i, 0, 0, 0);
      idle(8);

      // One sample while the enable toggles; the output holds while disabled
      step(1, 1, 1, 8'hA5, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, i % 2 == 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h11, 0, 0, 0);
      idle(6);

      // Clamping on an empty pipeline
      load(0);
      settle();
      check("clamp_low", int'(cur_n), 1);
      check("clamp_low_ready", int'(ready), 1);
      load(MAX_N + 5);
      settle();
      check("clamp_high", int'(cur_n), MAX_N);
      check("clamp_high_ready", int'(ready), 1);

      // Shrink while busy: drain at the old delay, then switch
      load(8);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h30 + i, 0, 0, 0);
      load(2);
      settle();
      check("drain_ready", int'(ready), 0);
      check("drain_cur_n", int'(cur_n), 8);
      wait_ready("drain", 30);
      check("after_drain_cur_n", int'(cur_n), 2);
      idle(4);

      // Second request mid-drain, then flush
      load(8);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h40 + i, 0, 0, 0);
      load(2);
      load(6);
      step(1, 1, 1, 8'hEE, 0, 0, 1);
      settle();
      check("flush_cur_n", int'(cur_n), 6);
      check("flush_ready", int'(ready), 1);
      check("flush_valid", int'(q_valid), 0);
      check("flush_busy", int'(busy), 0);
      idle(12);

      // Reset in the middle of a drain
      load(8);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 8'h50 + i, 0, 0, 0);
      load(2);
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 8'h77, 1, 3, 1);
      settle();
      check("mid_rst_valid", int'(q_valid), 0);
      check("mid_rst_cur_n", int'(cur_n), RST_N);
      check("mid_rst_ready", int'(ready), 1);
      idle(4);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 499) != 0,
              $urandom_range(0, 9) < 8,
              $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 255)),
              $urandom_range(0, 39) == 0,
              int'($urandom_range(0, (1 << CW) - 1)),
              $urandom_range(0, 149) == 0);
      end
      step(1, 1, 0, 0, 0, 0, 1);
      idle(MAX_N + 4);
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
